// File: rtl/perf_mon_pkg.sv
// Shared state encoding and default parameter values for the performance monitor.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_N_EVT    = 4;
  localparam int DEF_SAT_MODE = 0;
  localparam int DEF_WIN_CYC  = 0;

endpackage

// File: rtl/perf_cnt.sv
// Single event counter: enable, synchronous clear, wrap or saturate, sticky overflow.
// The next-state value is exported so a snapshot can include the current cycle's increment.
module perf_cnt
  import perf_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = DEF_SAT_MODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return (SAT_MODE != 0) ? CNT_MAX : '0;
    return v + CNT_W'(1);
  endfunction

  assign at_max = (cnt == CNT_MAX);

  always_comb begin
    cnt_next = cnt;
    if (clr)     cnt_next = '0;
    else if (en) cnt_next = bump(cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (clr)                ovf <= 1'b0;
      else if (en && at_max)  ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: cycle counter plus N_EVT event counters, run/stop FSM with
// optional cycle window, snapshot bank and registered snapshot readback.
module perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int N_EVT    = DEF_N_EVT,
  parameter int SAT_MODE = DEF_SAT_MODE,
  parameter int WIN_CYC  = DEF_WIN_CYC
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_clr,
  input  logic [N_EVT-1:0]           i_evt,
  input  logic                       i_snap,
  input  logic [$clog2(N_EVT+1)-1:0] i_rd_sel,
  output logic [CNT_W-1:0]           o_rd_data,
  output logic                       o_snap_vld,
  output logic [N_EVT:0]             o_ovf,
  output logic                       o_busy
);

  localparam int SEL_W = $clog2(N_EVT + 1);
  localparam int N_CH  = N_EVT + 1;

  state_t           state;
  state_t           state_nxt;
  logic             run;
  logic             end_run;
  logic             take_snap;
  logic             win_expire;
  logic [N_CH-1:0]  cnt_en;
  logic [CNT_W-1:0] cnt_next [N_CH];
  logic [CNT_W-1:0] snap_q   [N_CH];
  logic             snap_vld;
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] rd_data_p1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Clear beats stop/expiry, which beats start.
  always_comb begin
    state_nxt = state;
    end_run   = 1'b0;
    if (i_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (i_start) state_nxt = RUN;
        RUN: begin
          if (i_stop || win_expire) begin
            state_nxt = DONE;
            end_run   = 1'b1;
          end
        end
        DONE: if (i_start) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign run       = (state == RUN);
  assign take_snap = !i_clr && (i_snap || end_run);

  // Window counter is held at zero outside RUN, so every entry into RUN starts a fresh window.
  generate
    if (WIN_CYC > 0) begin : g_win
      localparam int WIN_W = $clog2(WIN_CYC + 1);
      logic [WIN_W-1:0] win_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)               win_cnt <= '0;
        else if (i_clr || !run)  win_cnt <= '0;
        else                     win_cnt <= win_cnt + WIN_W'(1);
      end

      assign win_expire = run && (win_cnt == WIN_W'(WIN_CYC - 1));
    end else begin : g_no_win
      assign win_expire = 1'b0;
    end
  endgenerate

  assign cnt_en[0]        = run;
  assign cnt_en[N_CH-1:1] = {N_EVT{run}} & i_evt;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    perf_cnt #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cnt (
      .clk      (i_clk),
      .rst      (i_rst),
      .clr      (i_clr),
      .en       (cnt_en[k]),
      .cnt_next (cnt_next[k]),
      .ovf      (o_ovf[k])
    );
  end

  // Snapshot stage: captures the counters' next values, so same-cycle increments are included.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_CH; k++) snap_q[k] <= '0;
      snap_vld <= 1'b0;
    end else if (i_clr) begin
      for (int k = 0; k < N_CH; k++) snap_q[k] <= '0;
      snap_vld <= 1'b0;
    end else if (take_snap) begin
      for (int k = 0; k < N_CH; k++) snap_q[k] <= cnt_next[k];
      snap_vld <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_rd_sel == SEL_W'(k)) rd_mux = snap_q[k];
    end
  end

  // Read stage: one register between select and data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rd_data_p1 <= '0;
    else       rd_data_p1 <= rd_mux;
  end

  assign o_rd_data  = rd_data_p1;
  assign o_snap_vld = snap_vld;
  assign o_busy     = run;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: four parameterisations share one stimulus stream; snapshot
// reads go through a scoreboard queue, control outputs are checked inline per scenario.
module tb_perf_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop, clr, snap;
  logic [3:0] evt;
  logic [2:0] rd_sel;

  logic [31:0] rd_m, rd_n;
  logic [7:0]  rd_w, rd_s;
  logic        vld_m, vld_w, vld_s, vld_n;
  logic [4:0]  ovf_m, ovf_w, ovf_s, ovf_n;
  logic        busy_m, busy_w, busy_s, busy_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          dut;
    int          due;
    logic [63:0] exp;
    string       nm;
  } rd_t;
  rd_t rd_q[$];

  perf_monitor #(.CNT_W(32), .N_EVT(4), .SAT_MODE(0), .WIN_CYC(0)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_clr(clr), .i_evt(evt),
    .i_snap(snap), .i_rd_sel(rd_sel), .o_rd_data(rd_m), .o_snap_vld(vld_m),
    .o_ovf(ovf_m), .o_busy(busy_m));

  perf_monitor #(.CNT_W(8), .N_EVT(4), .SAT_MODE(0), .WIN_CYC(0)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_clr(clr), .i_evt(evt),
    .i_snap(snap), .i_rd_sel(rd_sel), .o_rd_data(rd_w), .o_snap_vld(vld_w),
    .o_ovf(ovf_w), .o_busy(busy_w));

  perf_monitor #(.CNT_W(8), .N_EVT(4), .SAT_MODE(1), .WIN_CYC(0)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_clr(clr), .i_evt(evt),
    .i_snap(snap), .i_rd_sel(rd_sel), .o_rd_data(rd_s), .o_snap_vld(vld_s),
    .o_ovf(ovf_s), .o_busy(busy_s));

  perf_monitor #(.CNT_W(32), .N_EVT(4), .SAT_MODE(0), .WIN_CYC(100)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_clr(clr), .i_evt(evt),
    .i_snap(snap), .i_rd_sel(rd_sel), .o_rd_data(rd_n), .o_snap_vld(vld_n),
    .o_ovf(ovf_n), .o_busy(busy_n));

  function automatic logic [63:0] rd_of(input int d);
    case (d)
      0:       return {32'd0, rd_m};
      1:       return {56'd0, rd_w};
      2:       return {56'd0, rd_s};
      default: return {32'd0, rd_n};
    endcase
  endfunction

  // Scoreboard consumer: compares every read whose data is due this cycle.
  task automatic sb_monitor();
    rd_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        e = rd_q.pop_front();
        n_tests++;
        if (e.due != cyc || rd_of(e.dut) !== e.exp) begin
          n_fail++;
          $display("FAIL rd_%s: dut%0d o_rd_data=%0d, expected %0d (due %0d, now %0d)",
                   e.nm, e.dut, rd_of(e.dut), e.exp, e.due, cyc);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a read select and queue the value the selected DUT must return next cycle.
  task automatic rd(input int d, input int sel, input logic [63:0] exp, input string nm);
    rd_sel = 3'(sel);
    rd_q.push_back('{d, cyc + 1, exp, nm});
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && rd_q.size() != 0; i++) step();
    if (rd_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d reads still outstanding, expected 0", rd_q.size());
      rd_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; snap = 1'b0; evt = 4'd0; rd_sel = 3'd0;
    #12;
    n_tests++;
    if ({busy_m, vld_m, ovf_m, rd_m} !== 39'd0) begin
      n_fail++; $display("FAIL reset_main: busy=%b vld=%b ovf=%b rd=%0d, expected all 0", busy_m, vld_m, ovf_m, rd_m);
    end
    n_tests++;
    if ({busy_w, vld_w, ovf_w, rd_w, busy_s, vld_s, ovf_s, rd_s} !== 30'd0) begin
      n_fail++; $display("FAIL reset_8bit: w rd=%0d ovf=%b, s rd=%0d ovf=%b, expected 0", rd_w, ovf_w, rd_s, ovf_s);
    end
    @(negedge clk);
    rst = 1'b0;
    step(); step();
    n_tests++;
    if (busy_m !== 1'b0 || busy_n !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy_m=%b busy_n=%b, expected 0", busy_m, busy_n);
    end
    rd(0, 0, 64'd0, "reset_ch0"); step();
    rd(0, 4, 64'd0, "reset_ch4"); step();
    drain();
  endtask

  task automatic test_basic();
    logic [63:0] exp_b [8] = '{64'd11, 64'd11, 64'd11, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    step(); clr = 1'b1;
    step(); clr = 1'b0; start = 1'b1; evt = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      step(); start = (i == 4);
      if (i == 0) begin
        n_tests++;
        if (busy_m !== 1'b1) begin n_fail++; $display("FAIL basic_busy: o_busy=%b, expected 1", busy_m); end
      end
      if (i == 9) begin
        n_tests++;
        if (vld_m !== 1'b0) begin n_fail++; $display("FAIL basic_vld_pre: o_snap_vld=%b, expected 0", vld_m); end
      end
    end
    step(); start = 1'b0; stop = 1'b1;
    step(); stop = 1'b0; evt = 4'd0;
    n_tests++;
    if (busy_m !== 1'b0 || vld_m !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: busy=%b vld=%b, expected busy 0 vld 1", busy_m, vld_m);
    end
    for (int k = 0; k < 8; k++) begin
      rd(0, k, exp_b[k], $sformatf("basic_ch%0d", k));
      if (k == 0) rd(1, 0, 64'd11, "basic_w_ch0");
      step();
    end
    drain();
  endtask

  task automatic test_snap_run();
    step(); clr = 1'b1;
    step(); clr = 1'b0; start = 1'b1; evt = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(); start = 1'b0; snap = (i == 4);
      if (i == 4) begin
        n_tests++;
        if (vld_m !== 1'b0) begin n_fail++; $display("FAIL snaprun_vld_pre: o_snap_vld=%b, expected 0", vld_m); end
      end
    end
    step(); snap = 1'b0; evt = 4'd0;
    n_tests++;
    if (vld_m !== 1'b1) begin n_fail++; $display("FAIL snaprun_vld: o_snap_vld=%b, expected 1", vld_m); end
    rd(0, 0, 64'd5, "snaprun_ch0");
    step(); rd(0, 1, 64'd5, "snaprun_ch1");
    step(); stop = 1'b1; rd(0, 2, 64'd0, "snaprun_ch2");
    step(); stop = 1'b0; snap = 1'b1;
    step(); snap = 1'b0; rd(0, 0, 64'd8, "snapdone_ch0");
    step(); rd(0, 1, 64'd5, "snapdone_ch1");
    step(); start = 1'b1;
    step(); start = 1'b0; evt = 4'b0010;
    step(); stop = 1'b1;
    step(); stop = 1'b0; evt = 4'd0;
    n_tests++;
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL resume_busy: o_busy=%b, expected 0", busy_m); end
    rd(0, 0, 64'd10, "resume_ch0");
    step(); rd(0, 1, 64'd5, "resume_ch1");
    step(); rd(0, 2, 64'd2, "resume_ch2");
    step();
    drain();
  endtask

  task automatic test_wrap_sat();
    step(); clr = 1'b1;
    step(); clr = 1'b0; start = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      step(); start = 1'b0; stop = (i == 260);
      if (i == 256) begin
        n_tests++;
        if (ovf_w !== 5'b00000 || ovf_s !== 5'b00000) begin
          n_fail++; $display("FAIL ovf_early: wrap ovf=%b sat ovf=%b, expected 00000", ovf_w, ovf_s);
        end
      end
      if (i == 257) begin
        n_tests++;
        if (ovf_w !== 5'b00001 || ovf_s !== 5'b00001) begin
          n_fail++; $display("FAIL ovf_set: wrap ovf=%b sat ovf=%b, expected 00001", ovf_w, ovf_s);
        end
      end
    end
    step(); stop = 1'b0;
    n_tests++;
    if (ovf_m !== 5'b00000 || ovf_w !== 5'b00001 || busy_w !== 1'b0) begin
      n_fail++; $display("FAIL ovf_end: main ovf=%b wrap ovf=%b busy_w=%b, expected 00000 00001 0", ovf_m, ovf_w, busy_w);
    end
    rd(0, 0, 64'd260, "main_ch0_260"); rd(1, 0, 64'd4, "wrap_ch0"); rd(2, 0, 64'd255, "sat_ch0");
    step(); rd(1, 1, 64'd0, "wrap_ch1"); rd(2, 1, 64'd0, "sat_ch1");
    step();
    drain();
  endtask

  task automatic test_window();
    int fell = 0;
    int fell2 = 0;
    step(); clr = 1'b1;
    step(); clr = 1'b0; start = 1'b1;
    for (int i = 1; i <= 120 && fell == 0; i++) begin
      step(); start = 1'b0; evt = 4'(i & 1);
      if (busy_n === 1'b0) fell = i;
    end
    n_tests++;
    if (fell != 101) begin n_fail++; $display("FAIL win_fall: o_busy fell at cycle %0d, expected 101", fell); end
    n_tests++;
    if (busy_m !== 1'b1 || vld_n !== 1'b1) begin
      n_fail++; $display("FAIL win_state: busy_m=%b vld_n=%b, expected 1 1", busy_m, vld_n);
    end
    evt = 4'd0;
    rd(3, 0, 64'd100, "win_ch0");
    step(); rd(3, 1, 64'd50, "win_ch1"); stop = 1'b1;
    step(); stop = 1'b0; rd(3, 2, 64'd0, "win_ch2");
    step(); start = 1'b1;
    for (int i = 1; i <= 120 && fell2 == 0; i++) begin
      step(); start = 1'b0; evt = 4'(i & 1);
      if (busy_n === 1'b0) fell2 = i;
    end
    n_tests++;
    if (fell2 != 101) begin n_fail++; $display("FAIL win_rearm: o_busy fell at cycle %0d, expected 101", fell2); end
    evt = 4'd0;
    rd(3, 0, 64'd200, "win_rearm_ch0");
    step(); stop = 1'b1;
    step(); stop = 1'b0;
    drain();
  endtask

  task automatic test_collisions();
    n_tests++;
    if (vld_m !== 1'b1 || vld_n !== 1'b1) begin
      n_fail++; $display("FAIL coll_pre: vld_m=%b vld_n=%b, expected 1 1", vld_m, vld_n);
    end
    step(); clr = 1'b1; snap = 1'b1; start = 1'b1;
    step(); clr = 1'b0; snap = 1'b0; start = 1'b0;
    n_tests++;
    if (vld_m !== 1'b0 || vld_n !== 1'b0 || busy_m !== 1'b0) begin
      n_fail++; $display("FAIL coll_clr: vld_m=%b vld_n=%b busy_m=%b, expected 0 0 0", vld_m, vld_n, busy_m);
    end
    for (int k = 0; k < 5; k++) begin
      rd(0, k, 64'd0, $sformatf("clr_m_ch%0d", k));
      rd(3, k, 64'd0, $sformatf("clr_n_ch%0d", k));
      step();
    end
    start = 1'b1;
    step(); start = 1'b0;
    step();
    step();
    step(); stop = 1'b1; start = 1'b1; evt = 4'b0010;
    step(); stop = 1'b0; start = 1'b0; evt = 4'd0;
    n_tests++;
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL stop_over_start: o_busy=%b, expected 0", busy_m); end
    rd(0, 0, 64'd4, "stopevt_ch0");
    step(); rd(0, 2, 64'd1, "stopevt_ch2");
    step(); rd(0, 1, 64'd0, "stopevt_ch1");
    step();
    drain();
  endtask

  task automatic test_reset_abort();
    step(); clr = 1'b1;
    step(); clr = 1'b0; start = 1'b1; evt = 4'b1111;
    step(); start = 1'b0;
    step(); snap = 1'b1;
    step(); snap = 1'b0; rd(0, 0, 64'd2, "abort_pre_ch0");
    step();
    n_tests++;
    if (vld_m !== 1'b1 || busy_m !== 1'b1 || rd_m !== 32'd2) begin
      n_fail++; $display("FAIL abort_pre: vld=%b busy=%b rd=%0d, expected 1 1 2", vld_m, busy_m, rd_m);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy_m, vld_m, ovf_m, rd_m} !== 39'd0 || {busy_n, vld_n, busy_w, vld_w} !== 4'd0) begin
      n_fail++; $display("FAIL abort_async: busy=%b vld=%b ovf=%b rd=%0d, expected all 0", busy_m, vld_m, ovf_m, rd_m);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (busy_m !== 1'b0) begin n_fail++; $display("FAIL abort_idle%0d: o_busy=%b, expected 0", i, busy_m); end
    end
    snap = 1'b1;
    step(); snap = 1'b0; rd(0, 0, 64'd0, "abort_idle_ch0");
    step(); rd(0, 1, 64'd0, "abort_idle_ch1");
    step(); start = 1'b1;
    step(); start = 1'b0;
    step();
    step(); stop = 1'b1;
    step(); stop = 1'b0; evt = 4'd0;
    rd(0, 0, 64'd3, "abort_restart_ch0");
    step(); rd(0, 4, 64'd3, "abort_restart_ch4");
    step();
    drain();
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_basic();
    test_snap_run();
    test_wrap_sat();
    test_window();
    test_collisions();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
